add_seq: RTL and testbench

ADD_SEQ -- requirements
Module: add_seq

---
 rtl/add_seq_pkg.sv | 15 +
 rtl/adder_cl.sv | 30 +++
 rtl/add_seq.sv | 109 ++++++++++
 tb/tb_add_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared definitions for the slice-serial adder: FSM encoding and counter sizing.
package add_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Slice counter width: enough bits to index K slices, never narrower than one bit.
  function automatic int cnt_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/adder_cl.sv
// N-bit carry adder slice; also reports the carry into its MSB so the caller can form signed overflow.
module adder_cl #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = ci;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s     = p ^ c[N-1:0];
    co    = c[N];
    c_msb = c[N-1];
  end

endmodule

// File: rtl/add_seq.sv
// Slice-serial W = N*K bit adder: one N-bit adder reused over K cycles, low slice first.
module add_seq
  import add_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           ci,
  output logic           busy,
  output logic           done,
  output logic [N*K-1:0] s,
  output logic           co,
  output logic           ov,
  output state_t         state_dbg
);

  localparam int W  = N * K;
  localparam int CW = cnt_width(K);

  // Handshake: start is a request taken only while busy = 0; done pulses for one
  // cycle when s/co/ov are valid, and they hold until the next accepted start.

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          carry;
  logic [N-1:0]  a_sl;
  logic [N-1:0]  b_sl;
  logic [N-1:0]  sum_sl;
  logic          c_out;
  logic          c_msb;
  logic          last;

  assign last = (cnt == CW'(K - 1));
  assign a_sl = a_r[int'(cnt) * N +: N];
  assign b_sl = b_r[int'(cnt) * N +: N];

  adder_cl #(.N(N)) u_adder (
    .a     (a_sl),
    .b     (b_sl),
    .ci    (carry),
    .s     (sum_sl),
    .co    (c_out),
    .c_msb (c_msb)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_RUN) || (state == S_DONE);
    done      = (state == S_DONE);
    state_dbg = state;
  end

  // Operands are sampled only on an accepted start; results change only in RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      s     <= '0;
      co    <= 1'b0;
      ov    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            carry <= ci;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          s[int'(cnt) * N +: N] <= sum_sl;
          carry <= c_out;
          cnt   <= cnt + 1'b1;
          if (last) begin
            co <= c_out;
            ov <= c_msb ^ c_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq: directed corner cases plus randomized operations vs an arithmetic model.
module tb_add_seq;
  import add_seq_pkg::*;

  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
  logic         ov;
  state_t       state_dbg;

  add_seq #(.N(N), .K(K)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .busy      (busy),
    .done      (done),
    .s         (s),
    .co        (co),
    .ov        (ov),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {ov, co, s} per accepted start, popped at done.
  logic [W+1:0] exp_q[$];
  logic [W-1:0] prev_s;
  logic         prev_co;
  logic         prev_ov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ);
    longint us;
    longint sa;
    longint sb;
    longint ss;
    logic [W-1:0] sum;
    logic c;
    logic o;
    us  = longint'(av) + longint'(bv) + longint'(civ);
    sum = W'(us % (64'sd1 << W));
    c   = (us >= (64'sd1 << W));
    sa  = av[W-1] ? longint'(av) - (64'sd1 << W) : longint'(av);
    sb  = bv[W-1] ? longint'(bv) - (64'sd1 << W) : longint'(bv);
    ss  = sa + sb + longint'(civ);
    o   = (ss > ((64'sd1 << (W-1)) - 1)) || (ss < -(64'sd1 << (W-1)));
    return {o, c, sum};
  endfunction

  // Called at a negedge; returns at the idle negedge after done so a new start can follow at once.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ, input bit restart);
    logic [W+1:0] e;
    int cyc;
    a = av; b = bv; ci = civ; start = 1'b1;
    exp_q.push_back(model(av, bv, civ));
    @(negedge clock);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); ci = 1'($urandom_range(0, 1));
    cyc = 1;
    check("busy_after_start", 32'(busy), 32'd1);
    check("s_held_at_start", 32'(s), 32'(prev_s));
    while (!done && cyc < K + 4) begin
      start = restart && (cyc == 2);
      if (start) a = 16'h1111;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    if (!done) begin
      check("done_timeout", 32'(done), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      prev_s = '0; prev_co = 1'b0; prev_ov = 1'b0;
      return;
    end
    check("latency", 32'(cyc), 32'(K + 1));
    check("sum", 32'(s), 32'(e[W-1:0]));
    check("co", 32'(co), 32'(e[W]));
    check("ov", 32'(ov), 32'(e[W+1]));
    prev_s = e[W-1:0]; prev_co = e[W]; prev_ov = e[W+1];
    @(negedge clock);
    check("done_single", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic idle_hold(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); ci = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("hold_s", 32'(s), 32'(prev_s));
      check("hold_co_ov", 32'({co, ov}), 32'({prev_co, prev_ov}));
      check("hold_done", 32'(done), 32'd0);
    end
  endtask

  task automatic reset_mid_run();
    a = 16'hABCD; b = 16'h1357; ci = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_co", 32'(co), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    prev_s = '0; prev_co = 1'b0; prev_ov = 1'b0;
    for (int i = 0; i < K + 2; i++) begin
      @(negedge clock);
      check("rst_no_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
    prev_s = '0; prev_co = 1'b0; prev_ov = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_s", 32'(s), 32'd0);
    check("reset_co_ov", 32'({co, ov}), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(S_IDLE));
    @(negedge clock);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    idle_hold(3);
    reset_mid_run();
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle_hold($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
